// File: rtl/soc_pkg.sv
// Shared types and constants for the UART transmit arbitration path.
package soc_pkg;

    localparam int UART_BYTE_W = 8;
    localparam int STALL_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/stall_timer.sv
// Counts cycles in which the current owner holds valid low.
// expired stays high once the count reaches TIMEOUT_CYCLES.
module stall_timer
    import soc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [STALL_W-1:0] LIMIT = STALL_W'(TIMEOUT_CYCLES);

    logic [STALL_W-1:0] count;

    // Saturates rather than wrapping, so expired cannot fall back low by itself.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count >= LIMIT);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-requester, packet-atomic round-robin arbiter in front of one UART
// transmitter; the owner's byte stream passes through with no added latency.
module uart_tx_arbiter
    import soc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [UART_BYTE_W-1:0] req0_data,
    input  logic                   req0_valid,
    input  logic                   req0_last,
    output logic                   req0_ready,
    input  logic [UART_BYTE_W-1:0] req1_data,
    input  logic                   req1_valid,
    input  logic                   req1_last,
    output logic                   req1_ready,
    output logic [UART_BYTE_W-1:0] tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic [1:0]             grant,
    output logic                   timeout_pulse
);

    arb_state_e state, state_n;
    logic       last_served, last_served_n;
    logic       tmr_clear, tmr_enable, tmr_expired;

    stall_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_stall_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (tmr_clear),
        .enable (tmr_enable),
        .expired(tmr_expired)
    );

    // last_served resets to 1 so requester 0 wins the first contention.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            last_served <= 1'b1;
        end else begin
            state       <= state_n;
            last_served <= last_served_n;
        end
    end

    always_comb begin
        state_n       = state;
        last_served_n = last_served;
        tx_data       = '0;
        tx_valid      = 1'b0;
        req0_ready    = 1'b0;
        req1_ready    = 1'b0;
        grant         = 2'b00;
        timeout_pulse = 1'b0;
        tmr_clear     = 1'b0;
        tmr_enable    = 1'b0;
        case (state)
            ST_IDLE: begin
                tmr_clear = 1'b1;
                if (req0_valid && req1_valid) begin
                    state_n = last_served ? ST_GRANT0 : ST_GRANT1;
                end else if (req0_valid) begin
                    state_n = ST_GRANT0;
                end else if (req1_valid) begin
                    state_n = ST_GRANT1;
                end
            end
            ST_GRANT0: begin
                tx_data    = req0_data;
                tx_valid   = req0_valid;
                req0_ready = tx_ready;
                grant      = 2'b01;
                tmr_clear  = req0_valid;
                tmr_enable = !req0_valid;
                if (req0_valid && tx_ready && req0_last) begin
                    state_n       = ST_IDLE;
                    last_served_n = 1'b0;
                end else if (!req0_valid && tmr_expired) begin
                    timeout_pulse = 1'b1;
                    state_n       = ST_IDLE;
                    last_served_n = 1'b0;
                end
            end
            ST_GRANT1: begin
                tx_data    = req1_data;
                tx_valid   = req1_valid;
                req1_ready = tx_ready;
                grant      = 2'b10;
                tmr_clear  = req1_valid;
                tmr_enable = !req1_valid;
                if (req1_valid && tx_ready && req1_last) begin
                    state_n       = ST_IDLE;
                    last_served_n = 1'b1;
                end else if (!req1_valid && tmr_expired) begin
                    timeout_pulse = 1'b1;
                    state_n       = ST_IDLE;
                    last_served_n = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a packet-level model.
module tb_uart_tx_arbiter;

    localparam int T = 8;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] req0_data, req1_data, tx_data;
    logic       req0_valid, req0_last, req0_ready;
    logic       req1_valid, req1_last, req1_ready;
    logic       tx_valid, tx_ready, timeout_pulse;
    logic [1:0] grant;

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 1'b0;

    // Model: who owns the transmitter, who was served last, owner idle run.
    int m_owner = -1;
    int m_last  = 1;
    int m_idle  = 0;

    uart_tx_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .clock        (clock),
        .reset        (reset),
        .req0_data    (req0_data),
        .req0_valid   (req0_valid),
        .req0_last    (req0_last),
        .req0_ready   (req0_ready),
        .req1_data    (req1_data),
        .req1_valid   (req1_valid),
        .req1_last    (req1_last),
        .req1_ready   (req1_ready),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .grant        (grant),
        .timeout_pulse(timeout_pulse)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        req0_data = 8'h00; req0_valid = 1'b0; req0_last = 1'b0;
        req1_data = 8'h00; req1_valid = 1'b0; req1_last = 1'b0;
        tx_ready  = 1'b0;
    endtask

    task automatic apply_reset();
        cyc();
        reset = 1'b1;
        clear_inputs();
        cyc();
        cyc();
        reset = 1'b0;
        checking = 1'b1;
    endtask

    // Per-cycle comparison against the model, then advance the model.
    always @(negedge clock) begin
        logic       v, l;
        logic [7:0] d;
        logic       e_to;
        v = (m_owner == 1) ? req1_valid : req0_valid;
        l = (m_owner == 1) ? req1_last  : req0_last;
        d = (m_owner == 1) ? req1_data  : req0_data;
        e_to = (m_owner >= 0) && !v && (m_idle >= T);
        if (checking) begin
            check("m_grant", grant, (m_owner < 0) ? 0 : (1 << m_owner));
            check("m_tx_valid", tx_valid, (m_owner >= 0) && v);
            check("m_req0_ready", req0_ready, (m_owner == 0) && tx_ready);
            check("m_req1_ready", req1_ready, (m_owner == 1) && tx_ready);
            check("m_timeout", timeout_pulse, e_to);
            if (m_owner >= 0) check("m_tx_data", tx_data, d);
        end
        if (reset) begin
            m_owner = -1; m_last = 1; m_idle = 0;
        end else if (m_owner < 0) begin
            m_idle = 0;
            if (req0_valid && req1_valid) m_owner = 1 - m_last;
            else if (req0_valid) m_owner = 0;
            else if (req1_valid) m_owner = 1;
        end else if ((v && tx_ready && l) || e_to) begin
            m_last  = m_owner;
            m_owner = -1;
        end else begin
            m_idle = v ? 0 : m_idle + 1;
        end
    end

    initial begin
        reset = 1'b1;
        clear_inputs();
        apply_reset();

        // Reset state and single two-byte packet from requester 0.
        @(negedge clock);
        check("rst_grant", grant, 2'b00);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_ready", {req0_ready, req1_ready}, 2'b00);
        check("rst_timeout", timeout_pulse, 1'b0);
        cyc();
        req0_valid = 1'b1; req0_data = 8'h41; tx_ready = 1'b1;
        @(negedge clock);
        check("pkt_arb_grant", grant, 2'b00);
        check("pkt_arb_txv", tx_valid, 1'b0);
        cyc();
        @(negedge clock);
        check("pkt_b0_data", tx_data, 8'h41);
        check("pkt_b0_grant", grant, 2'b01);
        check("pkt_b0_ready", req0_ready, 1'b1);
        cyc();
        req0_data = 8'h42; req0_last = 1'b1;
        @(negedge clock);
        check("pkt_b1_data", tx_data, 8'h42);
        check("pkt_b1_grant", grant, 2'b01);
        cyc();
        req0_valid = 1'b0; req0_last = 1'b0;
        @(negedge clock);
        check("pkt_idle_grant", grant, 2'b00);

        // Contention after reset: req0 first, then req1.
        apply_reset();
        req0_valid = 1'b1; req0_data = 8'hA0; req0_last = 1'b1;
        req1_valid = 1'b1; req1_data = 8'hB1; req1_last = 1'b1;
        tx_ready = 1'b1;
        @(negedge clock);
        check("rr_arb", grant, 2'b00);
        cyc();
        @(negedge clock);
        check("rr_first", grant, 2'b01);
        check("rr_first_data", tx_data, 8'hA0);
        cyc();
        @(negedge clock);
        check("rr_bubble", grant, 2'b00);
        cyc();
        @(negedge clock);
        check("rr_second", grant, 2'b10);
        check("rr_second_data", tx_data, 8'hB1);
        cyc();
        clear_inputs();

        // Backpressure holds the byte without timing out.
        apply_reset();
        req1_valid = 1'b1; req1_data = 8'h55;
        @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            cyc();
            @(negedge clock);
            check("bp_data", tx_data, 8'h55);
            check("bp_valid", tx_valid, 1'b1);
            check("bp_timeout", timeout_pulse, 1'b0);
        end
        cyc();
        tx_ready = 1'b1; req1_last = 1'b1;
        @(negedge clock);
        check("bp_release", req1_ready, 1'b1);
        cyc();
        clear_inputs();

        // Timeout 8 cycles after the owner drops valid; pending req1 next.
        apply_reset();
        req0_valid = 1'b1; req0_data = 8'h11; tx_ready = 1'b1;
        @(negedge clock);
        cyc();
        @(negedge clock);
        check("to_grant", grant, 2'b01);
        cyc();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_data = 8'h77; req1_last = 1'b1;
        for (int k = 0; k < T; k++) begin
            @(negedge clock);
            check("to_early", timeout_pulse, 1'b0);
            check("to_hold", grant, 2'b01);
            cyc();
        end
        @(negedge clock);
        check("to_pulse", timeout_pulse, 1'b1);
        cyc();
        @(negedge clock);
        check("to_after", timeout_pulse, 1'b0);
        check("to_idle", grant, 2'b00);
        cyc();
        @(negedge clock);
        check("to_next", grant, 2'b10);
        check("to_next_data", tx_data, 8'h77);
        cyc();
        clear_inputs();

        // Reset during GRANT1 truncates; req0 wins the following contention.
        apply_reset();
        req1_valid = 1'b1; req1_data = 8'h10; tx_ready = 1'b1;
        @(negedge clock);
        cyc();
        @(negedge clock);
        check("mr_byte", tx_data, 8'h10);
        cyc();
        reset = 1'b1; req1_data = 8'h20;
        req0_valid = 1'b1; req0_data = 8'h5A; req0_last = 1'b1;
        cyc();
        reset = 1'b0;
        @(negedge clock);
        check("mr_grant", grant, 2'b00);
        check("mr_txv", tx_valid, 1'b0);
        cyc();
        @(negedge clock);
        check("mr_winner", grant, 2'b01);
        check("mr_data", tx_data, 8'h5A);
        cyc();
        clear_inputs();

        // Non-owner data and valid never leak through.
        apply_reset();
        req0_valid = 1'b1; req0_data = 8'h33; tx_ready = 1'b1;
        @(negedge clock);
        for (int i = 0; i < 6; i++) begin
            cyc();
            req0_data  = 8'(i + 1);
            req1_valid = 1'b1;
            req1_data  = (i % 2 == 1) ? 8'h00 : 8'hFF;
            @(negedge clock);
            check("iso_data", tx_data, 8'(i + 1));
            check("iso_ready1", req1_ready, 1'b0);
        end
        cyc();
        req0_last = 1'b1;
        cyc();
        clear_inputs();

        // Randomized traffic with busy and quiet phases per requester.
        begin
            int busy0, busy1;
            busy0 = 1; busy1 = 1;
            for (int c = 0; c < 4000; c++) begin
                cyc();
                if (c % 32 == 0) begin
                    busy0 = ($urandom_range(0, 2) != 0);
                    busy1 = ($urandom_range(0, 2) != 0);
                end
                reset      = ($urandom_range(0, 599) == 0);
                req0_valid = busy0 ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0);
                req1_valid = busy1 ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0);
                req0_last  = ($urandom_range(0, 3) == 0);
                req1_last  = ($urandom_range(0, 3) == 0);
                req0_data  = 8'($urandom);
                req1_data  = 8'($urandom);
                tx_ready   = ($urandom_range(0, 3) != 0);
            end
        end
        cyc();
        reset = 1'b0;
        clear_inputs();
        cyc();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 1023, stall cycles with owner valid low before the grant is revoked (range 1..65535).
REQ-002 Port: clock  in  1  single system clock; all state changes on the rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: req0_data  in  8  requester 0 byte.
REQ-005 Port: req0_valid  in  1  requester 0 byte valid.
REQ-006 Port: req0_last  in  1  requester 0 last byte of packet.
REQ-007 Port: req0_ready  out  1  requester 0 byte accepted.
REQ-008 Port: req1_data, req1_valid, req1_last, req1_ready: same widths, directions and meanings for requester 1.
REQ-009 Port: tx_data  out  8  byte to the shared UART transmitter.
REQ-010 Port: tx_valid  out  1  byte valid to the UART transmitter.
REQ-011 Port: tx_ready  in  1  UART transmitter accepts byte.
REQ-012 Port: grant  out  2  one-hot current owner; 2'b00 when idle.
REQ-013 Port: timeout_pulse  out  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-014 States: IDLE, GRANT0, GRANT1.
REQ-015 Transfer occurs on a cycle with tx_valid=1 and tx_ready=1.
REQ-016 IDLE: tx_valid=0, req0_ready=0, req1_ready=0, grant=2'b00.
REQ-017 IDLE with exactly one reqN_valid=1: next state GRANTN.
REQ-018 IDLE with both valid: grant the requester not served last (round-robin pointer); after reset requester 0 wins.
REQ-019 GRANTN: tx_data=reqN_data, tx_valid=reqN_valid, reqN_ready=tx_ready, other requester's ready=0, grant bit N=1 (combinational pass-through, zero added latency).
REQ-020 Arbitration latency: first byte appears on tx one cycle after reqN_valid is first seen in IDLE.
REQ-021 Transfer with reqN_last=1 in GRANTN: next state IDLE, pointer records N as last served; one idle bubble cycle between packets.
REQ-022 Packet atomicity: the grant is never switched mid-packet except by timeout or reset.
REQ-023 Stall counter (16 bit): clears on entry to GRANTN and on any cycle with reqN_valid=1; increments each GRANTN cycle with reqN_valid=0.
REQ-024 Counter reaching TIMEOUT_CYCLES: next state IDLE, timeout_pulse=1 for exactly that one cycle, pointer records N as last served.
REQ-025 Timeout never fires while tx_valid=1, so tx_valid/tx_data are never withdrawn before acceptance.
REQ-026 Non-owner valid is ignored, not counted, and its data never reaches tx_data.
REQ-027 last=1 on a byte not transferred has no effect.

Reset
REQ-028 On reset: state IDLE, pointer selects requester 0 first, stall counter 0, timeout_pulse 0.
REQ-029 Output values after reset: tx_valid 0, req0_ready 0, req1_ready 0, grant 2'b00, timeout_pulse 0.
REQ-030 Reset mid-packet truncates the packet; no state is preserved and no byte is replayed.

Structure
REQ-031 Shared package soc_pkg holds the arbiter state enumeration type and the constant UART_BYTE_W=8.
REQ-032 The stall counter is one sub-module, stall_timer (inputs clear/enable, output expired); all other logic stays in uart_tx_arbiter.

Verification
REQ-033 Single packet: req0 sends 0x41,0x42 (last on 0x42), tx_ready=1 -> tx shows 0x41 then 0x42, grant=2'b01 for two cycles, then IDLE.
REQ-034 Contention: both valid in IDLE after reset -> req0 packet first; both request again -> req1 granted next.
REQ-035 Backpressure: tx_ready=0 for 5 cycles with req1 byte 0x55 valid -> tx_data holds 0x55, tx_valid stays 1, no timeout.
REQ-036 Timeout, TIMEOUT_CYCLES=8: req0 sends one non-last byte then drops valid -> timeout_pulse 1 cycle, 8 cycles after the drop; pending req1 granted next.
REQ-037 Reset mid-packet: assert reset during GRANT1 after byte 0x10 -> next cycle grant=2'b00, tx_valid=0, next contention won by req0.
REQ-038 Isolation: req1 toggles data 0xFF/0x00 while req0 owns -> tx_data never shows req1 bytes, req1_ready stays 0.
